// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and constants for the round-robin mux-select arbiter.
// MAX_HOLD/HOLD_W only matter when ARB_TIMEOUT_EN is defined.
package arb_pkg;
  localparam int N_REQ    = 8;
  localparam int SEL_W    = 3;
  localparam int MAX_HOLD = 16;
  localparam int HOLD_W   = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, OWN} arb_state_t;
  typedef logic [N_REQ-1:0] req_vec_t;
endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Requester/arbiter handshake bundle: requests and releases in, one-hot grant and mux select out.
interface mux_sel_arbiter_if;
  arb_pkg::req_vec_t             req;
  arb_pkg::req_vec_t             done;
  arb_pkg::req_vec_t             grant;
  logic [arb_pkg::SEL_W-1:0]     sel;
  logic                          sel_valid;
  logic                          busy;
  logic                          timeout;

  modport master (
    output req, done,
    input  grant, sel, sel_valid, busy, timeout
  );

  modport slave (
    input  req, done,
    output grant, sel, sel_valid, busy, timeout
  );
endinterface

// File: rtl/mux_sel_arbiter_rr_pick8.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo 8.
module rr_pick8
  import arb_pkg::*;
(
  input  req_vec_t         req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);
  req_vec_t         w_rot;
  logic [SEL_W-1:0] w_off;
  logic             w_found;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    w_rot   = '0;
    w_off   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_rot[i] = req[SEL_W'(i) + ptr];
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_off   = SEL_W'(i);
        w_found = 1'b1;
      end
    end
  end

  assign any = |req;
  assign idx = w_off + ptr;
endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving a registered 3-bit select for a shared 8:1 mux.
// Define ARB_TIMEOUT_EN to bound each tenure to MAX_HOLD cycles with a timeout pulse.
module mux_sel_arbiter
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  mux_sel_arbiter_if.slave arb
);
  arb_state_t       r_state, w_state_nx;
  req_vec_t         r_grant, w_grant_nx;
  logic [SEL_W-1:0] r_sel, w_sel_nx;
  logic [SEL_W-1:0] r_ptr, w_ptr_nx;
  logic [SEL_W-1:0] w_idx;
  logic             w_any;
  logic             w_release;
  logic             w_force;

  rr_pick8 u_pick (
    .req (arb.req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  // r_sel always holds the current owner while in OWN.
  assign w_release = arb.done[r_sel] | ~arb.req[r_sel];

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] r_hold, w_hold_nx;
  logic              r_timeout;

  assign w_force   = ~w_release & (r_hold == HOLD_W'(MAX_HOLD - 1));
  // Counter runs only in OWN; it is zero again by the time the next tenure starts.
  assign w_hold_nx = (r_state == OWN) ? r_hold + HOLD_W'(1) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_hold    <= w_hold_nx;
      r_timeout <= (r_state == OWN) & w_force;
    end
  end

  assign arb.timeout = r_timeout;
`else
  assign w_force     = 1'b0;
  assign arb.timeout = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_sel_nx   = r_sel;
    w_ptr_nx   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nx = OWN;
          w_grant_nx = req_vec_t'(1) << w_idx;
          w_sel_nx   = w_idx;
        end
      end
      OWN: begin
        if (w_release || w_force) begin
          w_state_nx = IDLE;
          w_grant_nx = '0;
          w_ptr_nx   = r_sel + SEL_W'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_sel   <= w_sel_nx;
      r_ptr   <= w_ptr_nx;
    end
  end

  assign arb.grant     = r_grant;
  assign arb.sel       = r_sel;
  assign arb.sel_valid = |r_grant;
  assign arb.busy      = (r_state == OWN);
endmodule
